medidor_pulsos: RTL and testbench

Gated pulse counter (tachometer) for the motor speed sensor. It consumes the system clock and generates its own 1 s measurement window, matching the 1 Hz timebase used for motor cooling. It counts rising edges of the asynchronous sensor input within each window. At the end of each window it latches the count, with a one-cycle valid strobe, for the display/control logic.

---
 rtl/medidor_pulsos.sv | 153 +++++++++++++++
 tb/tb_medidor_pulsos.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/medidor_pulsos.sv
// Gated pulse counter: counts synchronized sensor rising edges over GATE_CYCLES-long windows.
// Optional glitch filter between synchronizer and edge detector when MEDIDOR_FILTRO_EN is defined.
module medidor_pulsos #(
  parameter int GATE_CYCLES = 27000000,
  parameter int CNT_W       = 16,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sensor_in,
  output logic [CNT_W-1:0] pulses_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  if ((GATE_CYCLES < 2) || (FILTER_LEN < 2) || (CNT_W < 1)) begin : g_bad_params
    $error("medidor_pulsos: GATE_CYCLES and FILTER_LEN must be >= 2, CNT_W >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  // Returns {saturation_hit, next_count}; the count sticks at CNT_MAX.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (!inc) return {1'b0, cnt};
    if (cnt == CNT_MAX) return {1'b1, cnt};
    return {1'b0, cnt + CNT_W'(1)};
  endfunction

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_prev_q;
  logic       pulse_edge;

  // Input path runs in every state so a level already high at enable is not an edge.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], sensor_in};
      lvl_prev_q <= lvl;
    end
  end

`ifdef MEDIDOR_FILTRO_EN
  localparam int               FW    = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0]    FLAST = FW'(FILTER_LEN - 1);

  logic          filt_q;
  logic [FW-1:0] fcnt_q;

  // Level flips only after FILTER_LEN consecutive samples disagreeing with it.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync_q[1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FLAST) begin
      filt_q <= sync_q[1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FW'(1);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  assign pulse_edge = lvl & ~lvl_prev_q;

  state_t           state_q;
  logic [GW-1:0]    gate_cnt_q;
  logic [CNT_W-1:0] pulse_cnt_q;
  logic             ovf_q;
  logic [CNT_W-1:0] pulses_q;
  logic             valid_q;
  logic             overflow_q;
  logic             busy_q;

  logic [CNT_W:0]   inc_d;
  logic             inc_hit;
  logic [CNT_W-1:0] inc_val;

  assign inc_d   = sat_inc(pulse_cnt_q, pulse_edge);
  assign inc_hit = inc_d[CNT_W];
  assign inc_val = inc_d[CNT_W-1:0];

  // The closing cycle latches the window including its own edge and restarts with no dead cycle.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gate_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      ovf_q       <= 1'b0;
      pulses_q    <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          gate_cnt_q  <= '0;
          pulse_cnt_q <= '0;
          ovf_q       <= 1'b0;
          if (en) begin
            state_q <= GATE;
            busy_q  <= 1'b1;
          end
        end
        GATE: begin
          if (!en) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            gate_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            ovf_q       <= 1'b0;
          end else if (gate_cnt_q == GATE_LAST) begin
            pulses_q    <= inc_val;
            overflow_q  <= ovf_q | inc_hit;
            valid_q     <= 1'b1;
            gate_cnt_q  <= '0;
            pulse_cnt_q <= '0;
            ovf_q       <= 1'b0;
          end else begin
            gate_cnt_q  <= gate_cnt_q + GW'(1);
            pulse_cnt_q <= inc_val;
            if (inc_hit) ovf_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pulses_out = pulses_q;
  assign valid      = valid_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_medidor_pulsos.sv
// Directed bench for medidor_pulsos: two instances (CNT_W=16 and CNT_W=4) share all inputs.
module tb_medidor_pulsos;

  localparam int GATE = 100;
`ifdef MEDIDOR_FILTRO_EN
  localparam int LAT  = 6;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, sensor;
  logic [15:0] p16;
  logic [3:0]  p4;
  logic        v16, v4, o16, o4, b16, b4;

  medidor_pulsos #(.GATE_CYCLES(GATE), .CNT_W(16), .FILTER_LEN(4)) dut16 (
    .clk_in(clk), .rst(rst_n), .en(en), .sensor_in(sensor),
    .pulses_out(p16), .valid(v16), .overflow(o16), .busy(b16)
  );

  medidor_pulsos #(.GATE_CYCLES(GATE), .CNT_W(4), .FILTER_LEN(4)) dut4 (
    .clk_in(clk), .rst(rst_n), .en(en), .sensor_in(sensor),
    .pulses_out(p4), .valid(v4), .overflow(o4), .busy(b4)
  );

  typedef struct {
    logic en;
    int   period;
    int   width;
    int   ncyc;
    logic exp_valid;
    logic exp_busy;
    int   exp_p16;
    int   exp_p4;
    logic exp_o16;
    logic exp_o4;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Each call drives ncyc negedges of pattern, then samples just after the following posedge.
  task automatic apply(input vec_t v, input string tag);
    for (int k = 0; k < v.ncyc; k++) begin
      @(negedge clk);
      en     = v.en;
      sensor = (v.period > 0) && ((k % v.period) < v.width);
    end
    @(posedge clk);
    #1;
    chk({tag, " valid16"},  32'(v16), 32'(v.exp_valid));
    chk({tag, " valid4"},   32'(v4),  32'(v.exp_valid));
    chk({tag, " busy16"},   32'(b16), 32'(v.exp_busy));
    chk({tag, " busy4"},    32'(b4),  32'(v.exp_busy));
    chk({tag, " pulses16"}, 32'(p16), v.exp_p16);
    chk({tag, " pulses4"},  32'(p4),  v.exp_p4);
    chk({tag, " ovf16"},    32'(o16), 32'(v.exp_o16));
    chk({tag, " ovf4"},     32'(o4),  32'(v.exp_o4));
  endtask

  int   n_valid = 0;
  int   mon_err = 0;
  logic v_prev  = 1'b0;

  always @(negedge clk) begin
    if (v16 === 1'b1) n_valid++;
    if ((v16 === 1'b1 && v_prev === 1'b1) || (v16 === 1'b1 && b16 !== 1'b1) || (v4 !== v16))
      mon_err++;
    v_prev <= v16;
  end

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0,  7,  3, 300, 1'b0, 1'b0,  0,  0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1,  0,  0,   1, 1'b0, 1'b1,  0,  0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 10,  5, 100, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 10,  5, 100, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 10,  5, 100, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 10,  5, 100, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 10,  5, 100, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[7]  = '{1'b1,  4,  2, 100, 1'b1, 1'b1, FILT ? 0 : 25, FILT ? 0 : 15, 1'b0, FILT ? 1'b0 : 1'b1};
    tbl[8]  = '{1'b1, 10,  5, 100, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 10,  5,  50, 1'b0, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[10] = '{1'b0,  0,  0,   1, 1'b0, 1'b0, 10, 10, 1'b0, 1'b0};
    tbl[11] = '{1'b0,  0,  0,  20, 1'b0, 1'b0, 10, 10, 1'b0, 1'b0};
    tbl[12] = '{1'b1,  0,  0,   1, 1'b0, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 20, 10,  99, 1'b0, 1'b1, 10, 10, 1'b0, 1'b0};
    tbl[14] = '{1'b1,  0,  0,   1, 1'b1, 1'b1,  5,  5, 1'b0, 1'b0};

    rst_n  = 1'b0;
    en     = 1'b0;
    sensor = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sensor = ~sensor;
    end
    @(negedge clk);
    sensor = 1'b0;
    #1;
    chk("reset pulses16", 32'(p16), 0);
    chk("reset valid16",  32'(v16), 0);
    chk("reset ovf16",    32'(o16), 0);
    chk("reset busy16",   32'(b16), 0);
    chk("reset pulses4",  32'(p4),  0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Rise placed so its edge lands on gate cycle 99 of this window.
    for (int k = 0; k < GATE; k++) begin
      @(negedge clk);
      sensor = ((k < 90) && ((k % 10) < 5)) || (k >= GATE - 1 - LAT);
    end
    @(posedge clk);
    #1;
    chk("boundary valid",    32'(v16), 1);
    chk("boundary pulses16", 32'(p16), 10);
    chk("boundary pulses4",  32'(p4),  10);

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      sensor = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst pulses16", 32'(p16), 0);
    chk("midrst pulses4",  32'(p4),  0);
    chk("midrst valid",    32'(v16), 0);
    chk("midrst ovf",      32'(o16), 0);
    chk("midrst busy16",   32'(b16), 0);
    chk("midrst busy4",    32'(b4),  0);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    apply('{1'b1, 0, 0, 1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0}, "reenable");
    apply('{1'b1, 10, 2, 100, 1'b1, 1'b1, FILT ? 0 : 10, FILT ? 0 : 10, 1'b0, 1'b0}, "narrow");
    apply('{1'b1, 10, 6, 100, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0}, "wide");

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("valid strobe total", 32'(n_valid), 11);
    chk("valid strobe rules", 32'(mon_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
